// File: rtl/alu_seq_unit.sv
// Sequential handshaked ALU for the 16-bit datapath.
// Single-cycle logic ops; MUL is shift-add and DIV is restoring, one step per clock.
module alu_seq_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             ZERO,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             wr;
  logic [WIDTH-1:0] wval;
  logic             wdbz;
  logic             last;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_nx;
  logic             ge;

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    wr       = 1'b0;
    wval     = '0;
    wdbz     = 1'b0;
    acc_step = acc_q + (b_q[0] ? a_q : '0);
    rem_sh   = {acc_q, a_q[WIDTH-1]};
    ge       = (rem_sh >= {1'b0, b_q});
    rem_nx   = ge ? (rem_sh - {1'b0, b_q}) : rem_sh;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (Opcode)
            3'b000: begin wr = 1'b1; wval = A + B; end
            3'b001: begin wr = 1'b1; wval = A - B; end
            3'b010: begin
              a_d     = A;
              b_d     = B;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            3'b011: begin
              if (B == '0) begin
                wr   = 1'b1;
                wval = '1;
                wdbz = 1'b1;
              end else begin
                a_d     = A;
                b_d     = B;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            3'b100: begin wr = 1'b1; wval = A | B; end
            3'b101: begin wr = 1'b1; wval = ~(A | B); end
            3'b110: begin wr = 1'b1; wval = ~(A & B); end
            3'b111: begin wr = 1'b1; wval = '0; end
          endcase
        end
      end
      S_MUL: begin
        acc_d = acc_step;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          wr      = 1'b1;
          wval    = acc_step;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        // quotient bits shift into a_q as dividend bits leave its MSB
        acc_d = rem_nx[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          wr      = 1'b1;
          wval    = {a_q[WIDTH-2:0], ge};
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr) begin
      res_d  = wval;
      zero_d = (wval == '0);
      dbz_d  = wdbz;
      done_d = 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign Result      = res_q;
  assign ZERO        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomized self-checking bench for alu_seq_unit.
// Reference model computes results with plain arithmetic on the operands.
module tb_alu_seq_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic [2:0]   Opcode;
  logic         busy, done, ZERO, div_by_zero;
  logic [W-1:0] Result;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] last_res;
  logic         last_zero;
  logic         last_dbz;

  alu_seq_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A(A),
    .B(B),
    .Opcode(Opcode),
    .busy(busy),
    .done(done),
    .Result(Result),
    .ZERO(ZERO),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] op,
                                         input int unsigned a,
                                         input int unsigned b);
    longint unsigned r;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a + 65536 - b;
      3'd2: r = longint'(a) * longint'(b);
      3'd3: r = (b == 0) ? 65535 : a / b;
      3'd4: r = a | b;
      3'd5: r = ~(a | b);
      3'd6: r = ~(a & b);
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk();
    start = 1'b0;
    step();
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", Result, last_res);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit noise);
    logic [W-1:0] er;
    logic         iter;
    int           n;
    er   = model(op, a, b);
    iter = (op == 3'd2) || (op == 3'd3 && b != 0);
    A = a; B = b; Opcode = op; start = 1'b1;
    step();
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Opcode = 3'($urandom);
    if (iter) begin
      chk("acc_busy", busy, 1);
      chk("acc_nodone", done, 0);
      n = 0;
      while (!done && n < 40) begin
        start = noise ? 1'($urandom) : 1'b0;
        A = W'($urandom); B = W'($urandom); Opcode = 3'($urandom);
        step();
        n++;
        if (!done) chk("iter_busy", busy, 1);
      end
      start = 1'b0;
      chk("latency", n, W);
    end
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("result", Result, er);
    chk("zero", ZERO, (er == 0));
    chk("dbz", div_by_zero, (op == 3'd3 && b == 0));
    last_res  = er;
    last_zero = (er == 0);
    last_dbz  = (op == 3'd3 && b == 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; A = 16'd5; B = 16'd7; Opcode = 3'd0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", Result, 0);
    chk("rst_zero", ZERO, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst = 1'b0; start = 1'b0;
    last_res = '0; last_zero = 1'b0; last_dbz = 1'b0;
    idle_chk();

    do_op(3'd0, 16'd12, 16'd35, 0);
    do_op(3'd1, 16'd35, 16'd12, 0);
    do_op(3'd1, 16'd12, 16'd35, 0);
    do_op(3'd1, 16'd10, 16'd10, 0);
    do_op(3'd4, 16'd12, 16'd5, 0);
    do_op(3'd5, 16'd12, 16'd5, 0);
    do_op(3'd6, 16'd12, 16'd5, 0);
    do_op(3'd7, 16'd12, 16'd5, 0);
    idle_chk();
    do_op(3'd2, 16'd100, 16'd69, 0);
    idle_chk();
    do_op(3'd2, 16'hFFFF, 16'd2, 1);
    do_op(3'd3, 16'd80, 16'd3, 1);
    do_op(3'd3, 16'd5, 16'd10, 0);
    do_op(3'd3, 16'd6, 16'd0, 0);
    idle_chk();

    // abort a multiply with reset partway through
    A = 16'd100; B = 16'd69; Opcode = 3'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", Result, 0);
    rst = 1'b0;
    last_res = '0;
    for (int i = 0; i < 20; i++) idle_chk();
    do_op(3'd0, 16'd1, 16'd1, 0);
    idle_chk();

    for (int i = 0; i < 60; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: b = a;
        default: b = W'($urandom);
      endcase
      do_op(op, a, b, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_chk();
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
